vector_writeback_arbiter: RTL and testbench
===========================================

VECTOR_WRITEBACK_ARBITER -- requirements
Module: vector_writeback_arbiter

Interface
REQ-001 SHALL have parameter LOAD_STARVE_LIMIT, default 4: number of consecutive refused load cycles before the load forces the RF port.
REQ-002 SHALL have ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- stall_i  input  1  upstream pipeline stall.
- flush_i  input  1  squash speculative results in stages 1-2.
- issue_write_i  input  1  result entering stage 1 writes a vector register.
- issue_register_i  input  REG_IDX_WIDTH  destination register.
- issue_mask_i  input  VECTOR_LANES  lane write mask.
- issue_value_i  input  VECTOR_BITS  result value.
- load_valid_i  input  1  memory load writeback request.
- load_register_i / load_mask_i / load_value_i  input  REG_IDX_WIDTH / VECTOR_LANES / VECTOR_BITS  load writeback payload.
- load_ready_o  output  1  load granted this cycle.
- stall_o  output  1  stages held because the load took the RF port.
- bypassN_register_o, N=1..4  output  REG_IDX_WIDTH  stage N destination.
- bypassN_write_o, N=1..4  output  1  stage N write flag.
- bypassN_mask_o, N=1..4  output  VECTOR_LANES  stage N mask.
- bypassN_value_o, N=1..4  output  VECTOR_BITS  stage N value.
- rf_write_en_o  output  1  register-file vector write enable.
- rf_write_reg_o / rf_write_mask_o / rf_write_value_o  output  REG_IDX_WIDTH / VECTOR_LANES / VECTOR_BITS  RF write payload.

Function
REQ-003 SHALL hold four stage registers {write, register, mask, value}; stage N drives bypassN_*_o directly.
REQ-004 Pipeline advances (issue->S1->S2->S3->S4) when neither stall_i nor stall_o is asserted.
REQ-005 Grant: load_wins = load_valid_i && (!S4.write || starve_cnt == LOAD_STARVE_LIMIT); load_ready_o = load_wins; combinational.
REQ-006 stall_o = load_wins && S4.write; combinational.
REQ-007 RF mux: load_wins -> load payload with rf_write_en_o=1; else S4 payload with rf_write_en_o = S4.write; combinational, zero added latency.
REQ-008 S4 commits when S4.write && !load_wins; on commit with stall_i asserted, S4.write clears to 0 next cycle (bubble) while S1-S3 hold.
REQ-009 When stall_o is asserted, S1-S4 all hold their contents unchanged.
REQ-010 starve_cnt: +1 when load_valid_i && !load_ready_o, saturating at LOAD_STARVE_LIMIT; cleared when load handshake completes or load_valid_i is low.
REQ-011 flush_i clears S1.write and S2.write on the next edge regardless of stalls; S3/S4 are unaffected; flush overrides the advance into S1/S2 (the issue is dropped).
REQ-012 Load payload must stay stable while load_valid_i is high and load_ready_o is low; the transfer occurs on the cycle both are high.
REQ-013 Stage register/mask/value fields are don't-care when write=0 but shall still shift.

Reset
REQ-014 On reset_n low: all stage write flags, registers, masks and values are 0; starve_cnt is 0; outputs are therefore rf_write_en_o=0, stall_o=0, and load_ready_o follows load_valid_i.
REQ-015 A reset asserted mid-stall or mid-starvation discards all in-flight results and never issues a partial RF write.

Configuration
REQ-016 Macro VECTOR_WB_STARVE_GUARD_EN defined: starvation counter and REQ-005/006 as written.
REQ-017 Macro undefined: no counter; load_wins = load_valid_i && !S4.write; stall_o tied 0; pipeline has strict priority.

Verification
REQ-018 Issue v3 (mask 0x000F, lanes 0xAA) with no stalls -> bypass1..4 show v3 on cycles 1-4; rf_write_en_o=1, reg=3 on cycle 4.
REQ-019 S4 empty and load_valid_i for v7 -> load_ready_o=1 the same cycle, rf_write_reg_o=7, stall_o=0.
REQ-020 Back-to-back issues with load_valid_i held (GUARD_EN, LIMIT=4) -> load refused for 4 cycles, granted on the 5th with stall_o=1, S1-S4 frozen one cycle, then resume.
REQ-021 flush_i with S1=v1, S2=v2, S3=v5 valid -> next cycle S2.write=0, S3.write=0 (squashed), S4=v5 still commits.
REQ-022 stall_i held 3 cycles with S4=v9 -> v9 commits once, S4.write=0 afterwards, S1-S3 unchanged, no duplicate RF write.
REQ-023 reset_n pulsed low while stall_o=1 -> all bypassN_write_o=0, rf_write_en_o=0 immediately, starve_cnt 0.

Source files
------------

// File: rtl/vector_writeback_arbiter.sv
// vector_writeback_arbiter
// Purpose : 4-stage vector result pipeline with bypass taps that shares one register-file
//           write port with memory load writebacks.
// Latency : an issued result commits from stage 4, 4 cycles after issue.
//           A granted load writes the register file in the same cycle (combinational mux).
// Backpressure: stall_i holds S1-S3. A stage-4 commit still drains into a bubble during stall_i.
//           The load handshake is load_valid_i / load_ready_o.
//           stall_o freezes S1-S4 whenever the load forces the port.
// Ports   : clk, reset_n (async, active-low); stall_i, flush_i;
//           issue_* (stage-1 input); load_* / load_ready_o (load writeback handshake);
//           stall_o; bypassN_* (stage N contents, N=1..4); rf_write_* (register-file port).
// Config  : define VECTOR_WB_STARVE_GUARD_EN to enable the load starvation guard.
//           Without it the pipeline has strict priority and stall_o is 0.
module vector_writeback_arbiter #(
   parameter int REG_IDX_WIDTH     = 5,
   parameter int VECTOR_LANES      = 16,
   parameter int VECTOR_BITS       = 128,
   parameter int LOAD_STARVE_LIMIT = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     stall_i,
   input  logic                     flush_i,
   input  logic                     issue_write_i,
   input  logic [REG_IDX_WIDTH-1:0] issue_register_i,
   input  logic [VECTOR_LANES-1:0]  issue_mask_i,
   input  logic [VECTOR_BITS-1:0]   issue_value_i,
   input  logic                     load_valid_i,
   input  logic [REG_IDX_WIDTH-1:0] load_register_i,
   input  logic [VECTOR_LANES-1:0]  load_mask_i,
   input  logic [VECTOR_BITS-1:0]   load_value_i,
   output logic                     load_ready_o,
   output logic                     stall_o,
   output logic [REG_IDX_WIDTH-1:0] bypass1_register_o,
   output logic                     bypass1_write_o,
   output logic [VECTOR_LANES-1:0]  bypass1_mask_o,
   output logic [VECTOR_BITS-1:0]   bypass1_value_o,
   output logic [REG_IDX_WIDTH-1:0] bypass2_register_o,
   output logic                     bypass2_write_o,
   output logic [VECTOR_LANES-1:0]  bypass2_mask_o,
   output logic [VECTOR_BITS-1:0]   bypass2_value_o,
   output logic [REG_IDX_WIDTH-1:0] bypass3_register_o,
   output logic                     bypass3_write_o,
   output logic [VECTOR_LANES-1:0]  bypass3_mask_o,
   output logic [VECTOR_BITS-1:0]   bypass3_value_o,
   output logic [REG_IDX_WIDTH-1:0] bypass4_register_o,
   output logic                     bypass4_write_o,
   output logic [VECTOR_LANES-1:0]  bypass4_mask_o,
   output logic [VECTOR_BITS-1:0]   bypass4_value_o,
   output logic                     rf_write_en_o,
   output logic [REG_IDX_WIDTH-1:0] rf_write_reg_o,
   output logic [VECTOR_LANES-1:0]  rf_write_mask_o,
   output logic [VECTOR_BITS-1:0]   rf_write_value_o
);

   if (LOAD_STARVE_LIMIT < 1) begin : g_bad_limit
      $error("LOAD_STARVE_LIMIT must be at least 1");
   end

   typedef struct packed {
      logic                     write;
      logic [REG_IDX_WIDTH-1:0] idx;
      logic [VECTOR_LANES-1:0]  mask;
      logic [VECTOR_BITS-1:0]   value;
   } stage_t;

   stage_t r_s1, r_s2, r_s3, r_s4;
   stage_t w_issue;
   logic   w_load_wins;
   logic   w_advance;
   logic   w_commit;

   assign w_issue = '{write: issue_write_i, idx: issue_register_i,
                      mask: issue_mask_i, value: issue_value_i};

`ifdef VECTOR_WB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(LOAD_STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LOAD_STARVE_LIMIT);

   logic [CNT_W-1:0] r_starve_cnt;

   // A starved load takes the port even over a valid stage-4 result; that result
   // and everything behind it freezes for the cycle (stall_o).
   assign w_load_wins = load_valid_i && (!r_s4.write || (r_starve_cnt == CNT_LIMIT));
   assign stall_o     = w_load_wins && r_s4.write;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_starve_cnt <= '0;
      end else if (!load_valid_i || load_ready_o) begin
         r_starve_cnt <= '0;
      end else if (r_starve_cnt != CNT_LIMIT) begin
         r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
   end
`else
   assign w_load_wins = load_valid_i && !r_s4.write;
   assign stall_o     = 1'b0;
`endif

   assign load_ready_o = w_load_wins;
   assign w_advance    = !stall_i && !stall_o;
   assign w_commit     = r_s4.write && !w_load_wins;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
         r_s4 <= '0;
      end else if (w_advance) begin
         // A flush kills whatever sits in S1/S2 wherever it moves next, so the
         // S2 result entering S3 is squashed too; the result already in S3 is kept.
         r_s1       <= w_issue;
         r_s1.write <= issue_write_i && !flush_i;
         r_s2       <= r_s1;
         r_s2.write <= r_s1.write && !flush_i;
         r_s3       <= r_s2;
         r_s3.write <= r_s2.write && !flush_i;
         r_s4       <= r_s3;
      end else begin
         if (flush_i) begin
            r_s1.write <= 1'b0;
            r_s2.write <= 1'b0;
         end
         // Under stall_i a committed S4 result becomes a bubble, so it is never
         // written twice. When stall_o holds, w_commit is 0 and S4 stays put.
         if (w_commit) begin
            r_s4.write <= 1'b0;
         end
      end
   end

   assign bypass1_write_o    = r_s1.write;
   assign bypass1_register_o = r_s1.idx;
   assign bypass1_mask_o     = r_s1.mask;
   assign bypass1_value_o    = r_s1.value;
   assign bypass2_write_o    = r_s2.write;
   assign bypass2_register_o = r_s2.idx;
   assign bypass2_mask_o     = r_s2.mask;
   assign bypass2_value_o    = r_s2.value;
   assign bypass3_write_o    = r_s3.write;
   assign bypass3_register_o = r_s3.idx;
   assign bypass3_mask_o     = r_s3.mask;
   assign bypass3_value_o    = r_s3.value;
   assign bypass4_write_o    = r_s4.write;
   assign bypass4_register_o = r_s4.idx;
   assign bypass4_mask_o     = r_s4.mask;
   assign bypass4_value_o    = r_s4.value;

   always_comb begin
      rf_write_en_o    = r_s4.write;
      rf_write_reg_o   = r_s4.idx;
      rf_write_mask_o  = r_s4.mask;
      rf_write_value_o = r_s4.value;
      if (w_load_wins) begin
         rf_write_en_o    = 1'b1;
         rf_write_reg_o   = load_register_i;
         rf_write_mask_o  = load_mask_i;
         rf_write_value_o = load_value_i;
      end
   end

endmodule

// File: tb/tb_vector_writeback_arbiter.sv
// tb_vector_writeback_arbiter
// Directed stimulus with a register-file write scoreboard.
// Stimulus pushes the expected writes; a negedge monitor pops and compares them.
module tb_vector_writeback_arbiter;

   logic         clk;
   logic         reset_n;
   logic         stall_i, flush_i;
   logic         issue_write_i;
   logic [4:0]   issue_register_i;
   logic [15:0]  issue_mask_i;
   logic [127:0] issue_value_i;
   logic         load_valid_i;
   logic [4:0]   load_register_i;
   logic [15:0]  load_mask_i;
   logic [127:0] load_value_i;
   logic         load_ready_o, stall_o;
   logic [4:0]   b1_r, b2_r, b3_r, b4_r;
   logic         b1_w, b2_w, b3_w, b4_w;
   logic [15:0]  b1_m, b2_m, b3_m, b4_m;
   logic [127:0] b1_v, b2_v, b3_v, b4_v;
   logic         rf_write_en_o;
   logic [4:0]   rf_write_reg_o;
   logic [15:0]  rf_write_mask_o;
   logic [127:0] rf_write_value_o;

   vector_writeback_arbiter #(
      .REG_IDX_WIDTH(5), .VECTOR_LANES(16), .VECTOR_BITS(128), .LOAD_STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .flush_i(flush_i),
      .issue_write_i(issue_write_i), .issue_register_i(issue_register_i),
      .issue_mask_i(issue_mask_i), .issue_value_i(issue_value_i),
      .load_valid_i(load_valid_i), .load_register_i(load_register_i),
      .load_mask_i(load_mask_i), .load_value_i(load_value_i),
      .load_ready_o(load_ready_o), .stall_o(stall_o),
      .bypass1_register_o(b1_r), .bypass1_write_o(b1_w), .bypass1_mask_o(b1_m), .bypass1_value_o(b1_v),
      .bypass2_register_o(b2_r), .bypass2_write_o(b2_w), .bypass2_mask_o(b2_m), .bypass2_value_o(b2_v),
      .bypass3_register_o(b3_r), .bypass3_write_o(b3_w), .bypass3_mask_o(b3_m), .bypass3_value_o(b3_v),
      .bypass4_register_o(b4_r), .bypass4_write_o(b4_w), .bypass4_mask_o(b4_m), .bypass4_value_o(b4_v),
      .rf_write_en_o(rf_write_en_o), .rf_write_reg_o(rf_write_reg_o),
      .rf_write_mask_o(rf_write_mask_o), .rf_write_value_o(rf_write_value_o)
   );

   typedef struct packed {
      logic [4:0]   r;
      logic [15:0]  m;
      logic [127:0] v;
   } wb_t;

   wb_t exp_q[$];
   wb_t mon_e;
   int  checks   = 0;
   int  failures = 0;

`ifdef VECTOR_WB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
   localparam int G_CYC = 8;
`else
   localparam bit GUARD = 1'b0;
   localparam int G_CYC = 12;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [127:0] mk(input logic [7:0] b);
      return {16{b}};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [4:0] r, input logic [15:0] m, input logic [127:0] v);
      exp_q.push_back('{r: r, m: m, v: v});
   endtask

   task automatic idle();
      issue_write_i = 1'b0; issue_register_i = '0; issue_mask_i = '0; issue_value_i = '0;
      load_valid_i = 1'b0; load_register_i = '0; load_mask_i = '0; load_value_i = '0;
      stall_i = 1'b0; flush_i = 1'b0;
   endtask

   task automatic issue(input logic [4:0] r, input logic [15:0] m, input logic [127:0] v);
      issue_write_i = 1'b1; issue_register_i = r; issue_mask_i = m; issue_value_i = v;
   endtask

   task automatic load(input logic [4:0] r, input logic [15:0] m, input logic [127:0] v);
      load_valid_i = 1'b1; load_register_i = r; load_mask_i = m; load_value_i = v;
   endtask

   // Each cycle: drive 1 time unit after the rising edge, check 1 unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Scoreboard monitor: every register-file write must match the next expected one.
   always @(negedge clk) begin
      if (rf_write_en_o) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rf_unexpected: got write reg %0d expected no write", rf_write_reg_o);
         end else begin
            mon_e = exp_q.pop_front();
            if ({rf_write_reg_o, rf_write_mask_o, rf_write_value_o} !== mon_e) begin
               failures++;
               $display("FAIL rf_write: got reg %0d mask %0h val %0h expected reg %0d mask %0h val %0h",
                        rf_write_reg_o, rf_write_mask_o, rf_write_value_o, mon_e.r, mon_e.m, mon_e.v);
            end
         end
      end
   end

   initial begin
      idle();
      reset_n = 1'b0;
      cyc(); cyc();
      settle();
      chk("reset_bypass_writes", {b4_w, b3_w, b2_w, b1_w}, 4'b0000);
      chk("reset_rf_en", rf_write_en_o, 1'b0);
      chk("reset_stall_o", stall_o, 1'b0);
      chk("reset_ready", load_ready_o, 1'b0);
      chk("reset_b4_value", b4_v, '0);
      reset_n = 1'b1;
      cyc();

      // Single issue flows through all four bypass taps, commits on cycle 4.
      idle(); issue(5'd3, 16'h000F, mk(8'hAA)); push(5'd3, 16'h000F, mk(8'hAA));
      cyc(); idle(); settle();
      chk("s1_write", b1_w, 1'b1); chk("s1_reg", b1_r, 5'd3);
      cyc(); settle();
      chk("s2_write", b2_w, 1'b1); chk("s2_mask", b2_m, 16'h000F); chk("s1_empty", b1_w, 1'b0);
      cyc(); settle();
      chk("s3_value", b3_v, mk(8'hAA));
      cyc(); settle();
      chk("s4_write", b4_w, 1'b1); chk("rf_en_c4", rf_write_en_o, 1'b1); chk("rf_reg_c4", rf_write_reg_o, 5'd3);
      cyc(); settle();
      chk("rf_en_after", rf_write_en_o, 1'b0);

      // Load into an empty stage 4 is granted in the same cycle.
      idle(); load(5'd7, 16'h00FF, mk(8'h55)); push(5'd7, 16'h00FF, mk(8'h55)); settle();
      chk("load_ready_empty", load_ready_o, 1'b1); chk("load_rf_reg", rf_write_reg_o, 5'd7);
      chk("load_stall_o", stall_o, 1'b0);
      cyc(); idle();

      // Back-to-back issues with a load held from the cycle stage 4 first fills.
      if (GUARD) begin
         for (int k = 0; k < 4; k++) push(5'(10 + k), 16'(1 << k), mk(8'(8'h10 + k)));
         push(5'd20, 16'hFFFF, mk(8'hCC));
         for (int k = 4; k < 8; k++) push(5'(10 + k), 16'(1 << k), mk(8'(8'h10 + k)));
      end else begin
         for (int k = 0; k < 8; k++) push(5'(10 + k), 16'(1 << k), mk(8'(8'h10 + k)));
         push(5'd20, 16'hFFFF, mk(8'hCC));
      end
      for (int c = 0; c < 16; c++) begin
         cyc(); idle();
         if (c < 8) issue(5'(10 + c), 16'(1 << c), mk(8'(8'h10 + c)));
         if (c >= 4 && c <= G_CYC) load(5'd20, 16'hFFFF, mk(8'hCC));
         settle();
         if (c >= 4 && c <= G_CYC) chk($sformatf("starve_ready_c%0d", c), load_ready_o, (c == G_CYC));
         if (c >= 4 && c <= G_CYC) chk($sformatf("starve_stall_c%0d", c), stall_o, GUARD && (c == G_CYC));
         if (c == G_CYC) chk("starve_rf_reg", rf_write_reg_o, 5'd20);
         if (c == 9) begin
            chk("starve_s4_reg_c9", b4_r, GUARD ? 5'd14 : 5'd15);
            chk("starve_s1_write_c9", b1_w, GUARD);
         end
      end

      // Flush squashes S1/S2 contents and the concurrent issue; S3 result survives.
      cyc(); idle(); issue(5'd5, 16'h0005, mk(8'h05)); push(5'd5, 16'h0005, mk(8'h05));
      cyc(); idle(); issue(5'd2, 16'h0002, mk(8'h02));
      cyc(); idle(); issue(5'd1, 16'h0001, mk(8'h01));
      cyc(); idle(); issue(5'd6, 16'h0006, mk(8'h06)); flush_i = 1'b1; settle();
      chk("flush_pre_s3", b3_r, 5'd5); chk("flush_pre_s1", b1_r, 5'd1);
      cyc(); idle(); settle();
      chk("flush_s4_write", b4_w, 1'b1); chk("flush_s4_reg", b4_r, 5'd5);
      chk("flush_s3_s2_s1", {b3_w, b2_w, b1_w}, 3'b000);
      cyc(); cyc(); cyc();

      // stall_i for 3 cycles with v9 in S4: exactly one commit, then a bubble.
      push(5'd9, 16'h0009, mk(8'h09)); push(5'd8, 16'h0008, mk(8'h08));
      push(5'd6, 16'h0006, mk(8'h06)); push(5'd4, 16'h0004, mk(8'h04));
      cyc(); idle(); issue(5'd9, 16'h0009, mk(8'h09));
      cyc(); idle(); issue(5'd8, 16'h0008, mk(8'h08));
      cyc(); idle(); issue(5'd6, 16'h0006, mk(8'h06));
      cyc(); idle(); issue(5'd4, 16'h0004, mk(8'h04));
      cyc(); idle(); stall_i = 1'b1; settle();
      chk("stall_commit_en", rf_write_en_o, 1'b1); chk("stall_commit_reg", rf_write_reg_o, 5'd9);
      cyc(); idle(); stall_i = 1'b1; settle();
      chk("stall_bubble", b4_w, 1'b0); chk("stall_rf_en", rf_write_en_o, 1'b0);
      chk("stall_hold_s3", {b3_w, b3_r}, {1'b1, 5'd8});
      chk("stall_hold_s2_s1", {b2_r, b1_r}, {5'd6, 5'd4});
      cyc(); idle(); stall_i = 1'b1; settle();
      chk("stall_bubble2", b4_w, 1'b0); chk("stall_hold_s1", b1_r, 5'd4);
      cyc(); idle(); settle();
      chk("stall_release_s4", b4_w, 1'b0);
      cyc(); idle(); settle();
      chk("stall_resume_reg", rf_write_reg_o, 5'd8);
      cyc(); cyc(); cyc();

      // Reset mid-stall discards in-flight results immediately.
      push(5'd21, 16'h0021, mk(8'h21));
      cyc(); idle(); issue(5'd21, 16'h0021, mk(8'h21));
      cyc(); idle(); issue(5'd22, 16'h0022, mk(8'h22));
      cyc(); idle(); issue(5'd23, 16'h0023, mk(8'h23));
      cyc(); idle(); issue(5'd24, 16'h0024, mk(8'h24));
      cyc(); idle(); stall_i = 1'b1; settle();
      chk("rst_pre_commit", rf_write_reg_o, 5'd21);
      cyc(); idle(); stall_i = 1'b1; reset_n = 1'b0; settle();
      chk("rst_bypass_writes", {b4_w, b3_w, b2_w, b1_w}, 4'b0000);
      chk("rst_rf_en", rf_write_en_o, 1'b0); chk("rst_s4_reg", b4_r, 5'd0);
      chk("rst_stall_o", stall_o, 1'b0);
      cyc(); idle();
      cyc(); reset_n = 1'b1;
      idle(); issue(5'd25, 16'h0025, mk(8'h25)); push(5'd25, 16'h0025, mk(8'h25));
      cyc(); idle();

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc();
      cyc();
      chk("drain_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
